// File: rtl/receiver.sv
// UART 8N1 receive stage: oversamples the serial line on clken, validates start
// and stop bits and holds each good byte behind a host-cleared ready flag.
module receiver #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clken,
  input  logic                 rx,
  input  logic                 rdy_clr,
  output logic [DATA_BITS-1:0] data,
  output logic                 rdy,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 rx_busy
);

  localparam int unsigned SW = $clog2(OVERSAMPLE);
  localparam int unsigned DW = DATA_BITS;
  localparam logic [SW-1:0] HALF_M1  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] FULL_M1  = SW'(OVERSAMPLE - 1);
  localparam logic [2:0]    LAST_BIT = 3'(DW - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   sample_q, sample_d;
  logic [2:0]      bitpos_q, bitpos_d;
  logic [DW-1:0]   shreg_q, shreg_d;
  logic [DW-1:0]   data_q, data_d;
  logic            rdy_q, rdy_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;
  logic            rx_busy_q, rx_busy_d;
  logic            rx_meta_q, rx_s_q;

  // Next-state and output logic; counters only advance on clken ticks.
  always_comb begin
    state_d     = state_q;
    sample_d    = sample_q;
    bitpos_d    = bitpos_q;
    shreg_d     = shreg_q;
    data_d      = data_q;
    rdy_d       = rdy_q;
    frame_err_d = frame_err_q;
    overrun_d   = overrun_q;

    if (rdy_clr) rdy_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (clken && !rx_s_q) begin
          state_d  = START;
          sample_d = '0;
        end
      end
      START: begin
        if (clken) begin
          sample_d = sample_q + SW'(1);
          if (sample_q == HALF_M1) begin
            sample_d = '0;
            bitpos_d = '0;
            state_d  = rx_s_q ? IDLE : DATA;
          end
        end
      end
      DATA: begin
        if (clken) begin
          sample_d = sample_q + SW'(1);
          if (sample_q == FULL_M1) begin
            shreg_d  = {rx_s_q, shreg_q[DW-1:1]};
            sample_d = '0;
            bitpos_d = bitpos_q + 3'd1;
            if (bitpos_q == LAST_BIT) begin
              bitpos_d = '0;
              state_d  = STOP;
            end
          end
        end
      end
      STOP: begin
        if (clken) begin
          sample_d = sample_q + SW'(1);
          // Leave at mid stop bit so a start edge half a bit later is caught.
          if (sample_q == FULL_M1) begin
            sample_d = '0;
            state_d  = IDLE;
            if (rx_s_q) begin
              data_d      = shreg_q;
              rdy_d       = 1'b1;
              frame_err_d = 1'b0;
              overrun_d   = rdy_q & ~rdy_clr;
            end else begin
              frame_err_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    rx_busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sample_q    <= '0;
      bitpos_q    <= '0;
      shreg_q     <= '0;
      data_q      <= '0;
      rdy_q       <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      rx_busy_q   <= 1'b0;
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      sample_q    <= sample_d;
      bitpos_q    <= bitpos_d;
      shreg_q     <= shreg_d;
      data_q      <= data_d;
      rdy_q       <= rdy_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      rx_busy_q   <= rx_busy_d;
      rx_meta_q   <= rx;
      rx_s_q      <= rx_meta_q;
    end
  end

  assign data      = data_q;
  assign rdy       = rdy_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign rx_busy   = rx_busy_q;

endmodule

// File: tb/tb_receiver.sv
// Scoreboard bench for receiver: each frame attempt queues its expected outcome,
// a monitor compares outputs whenever rx_busy falls (end of a frame attempt).
module tb_receiver;

  localparam int unsigned OS = 16;

  logic       clk     = 1'b0;
  logic       clken   = 1'b0;
  logic       rst     = 1'b1;
  logic       rx      = 1'b1;
  logic       rdy_clr = 1'b0;
  logic [7:0] data;
  logic       rdy, frame_err, overrun, rx_busy;

  int          checks   = 0;
  int          errors   = 0;
  int unsigned div      = 1;
  int unsigned cnt      = 0;
  bit          abort_tx = 1'b0;
  logic        busy_prev = 1'b0;

  typedef struct packed {
    logic [7:0] data;
    logic       rdy;
    logic       fe;
    logic       ov;
  } exp_t;

  exp_t exp_q[$];

  receiver #(.OVERSAMPLE(OS), .DATA_BITS(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .clken     (clken),
    .rx        (rx),
    .rdy_clr   (rdy_clr),
    .data      (data),
    .rdy       (rdy),
    .frame_err (frame_err),
    .overrun   (overrun),
    .rx_busy   (rx_busy)
  );

  always #5 clk = ~clk;

  // One clken pulse every div clocks, changed away from the rising edge.
  always @(negedge clk) begin
    if (cnt + 1 >= div) begin
      cnt   = 0;
      clken = 1'b1;
    end else begin
      cnt   = cnt + 1;
      clken = 1'b0;
    end
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endfunction

  function automatic void expect_ev(input logic [7:0] d, input logic r, input logic f, input logic o);
    exp_t e;
    e.data = d;
    e.rdy  = r;
    e.fe   = f;
    e.ov   = o;
    exp_q.push_back(e);
  endfunction

  // Monitor: end of any frame attempt (good, bad, glitch or reset abort).
  always @(negedge clk) begin
    exp_t e;
    if (busy_prev && !rx_busy) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_frame_end: got data %0h with no expected entry", data);
      end else begin
        e = exp_q.pop_front();
        check("data",      32'(data),      32'(e.data));
        check("rdy",       32'(rdy),       32'(e.rdy));
        check("frame_err", 32'(frame_err), 32'(e.fe));
        check("overrun",   32'(overrun),   32'(e.ov));
      end
    end
    busy_prev = rx_busy;
  end

  task automatic wait_ticks(input int n, output bit aborted);
    aborted = 1'b0;
    for (int k = 0; k < n; ) begin
      @(posedge clk);
      if (clken) k++;
      if (abort_tx) begin
        aborted = 1'b1;
        return;
      end
    end
  endtask

  // Transmitter model: start, 8 data bits LSB first, stop bit of the given value.
  task automatic send(input logic [7:0] b, input logic stop);
    bit ab;
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      #1 rx = fr[i];
      wait_ticks(OS, ab);
      if (ab) begin
        #1 rx = 1'b1;
        return;
      end
    end
    #1 rx = 1'b1;
  endtask

  task automatic idle_ticks(input int n);
    bit ab;
    wait_ticks(n, ab);
  endtask

  task automatic pulse_clr();
    @(posedge clk);
    #1 rdy_clr = 1'b1;
    @(posedge clk);
    #1 rdy_clr = 1'b0;
  endtask

  initial begin
    int t;
    bit ab;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_data",      32'(data),      32'h00);
    check("reset_rdy",       32'(rdy),       32'h0);
    check("reset_frame_err", 32'(frame_err), 32'h0);
    check("reset_overrun",   32'(overrun),   32'h0);
    check("reset_rx_busy",   32'(rx_busy),   32'h0);
    idle_ticks(4);

    // Basic frame, then host clears rdy.
    expect_ev(8'hA5, 1'b1, 1'b0, 1'b0);
    send(8'hA5, 1'b1);
    pulse_clr();
    #1 check("clr_rdy", 32'(rdy), 32'h0);
    idle_ticks(4);

    // Start-bit glitch of 5 ticks.
    expect_ev(8'hA5, 1'b0, 1'b0, 1'b0);
    #1 rx = 1'b0;
    idle_ticks(5);
    #1 rx = 1'b1;
    idle_ticks(30);

    // Bad stop bit; its low tail after mid stop looks like a second short glitch.
    expect_ev(8'hA5, 1'b0, 1'b1, 1'b0);
    expect_ev(8'hA5, 1'b0, 1'b1, 1'b0);
    send(8'h3C, 1'b0);
    idle_ticks(30);
    expect_ev(8'h11, 1'b1, 1'b0, 1'b0);
    send(8'h11, 1'b1);
    pulse_clr();
    idle_ticks(4);

    // Overrun: back-to-back frames without clearing rdy.
    expect_ev(8'h01, 1'b1, 1'b0, 1'b0);
    expect_ev(8'h02, 1'b1, 1'b0, 1'b1);
    send(8'h01, 1'b1);
    send(8'h02, 1'b1);
    pulse_clr();
    #1 check("overrun_sticky", 32'(overrun), 32'h1);
    idle_ticks(4);

    // Same pair, rdy_clr lands on the completion clock of the second frame.
    expect_ev(8'h01, 1'b1, 1'b0, 1'b0);
    expect_ev(8'h02, 1'b1, 1'b0, 1'b0);
    send(8'h01, 1'b1);
    fork
      send(8'h02, 1'b1);
      begin
        repeat (154) @(posedge clk);
        #1 rdy_clr = 1'b1;
        @(posedge clk);
        #1 rdy_clr = 1'b0;
      end
    join
    pulse_clr();
    idle_ticks(4);

    // Loopback rate: clken every 3rd clock.
    div = 3;
    idle_ticks(4);
    expect_ev(8'h00, 1'b1, 1'b0, 1'b0);
    send(8'h00, 1'b1);
    pulse_clr();
    #1 check("lb_clr0", 32'(rdy), 32'h0);
    expect_ev(8'hFF, 1'b1, 1'b0, 1'b0);
    send(8'hFF, 1'b1);
    pulse_clr();
    #1 check("lb_clr1", 32'(rdy), 32'h0);
    expect_ev(8'h55, 1'b1, 1'b0, 1'b0);
    send(8'h55, 1'b1);
    pulse_clr();
    #1 check("lb_clr2", 32'(rdy), 32'h0);
    idle_ticks(4);

    // Reset in the middle of a byte aborts it.
    expect_ev(8'h00, 1'b0, 1'b0, 1'b0);
    fork
      send(8'h96, 1'b1);
    join_none
    wait_ticks(60, ab);
    #2;
    rst      = 1'b1;
    abort_tx = 1'b1;
    @(posedge clk);
    #1 check("abort_rx_busy", 32'(rx_busy), 32'h0);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    abort_tx = 1'b0;
    repeat (200) @(posedge clk);
    #1 check("abort_no_rdy", 32'(rdy), 32'h0);
    check("abort_idle", 32'(rx_busy), 32'h0);

    t = 0;
    while (exp_q.size() != 0 && t < 5000) begin
      @(posedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d expected frames never completed", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
